seg7_scan: RTL and testbench
============================

# seg7_scan

Multiplexed scan driver for the board's 8-digit common-anode seven-segment display. It holds a 32-bit value and cycles through its eight nibbles one digit at a time, driving the active-low anode enables. Each selected nibble goes to the downstream hex-to-segment decoder; the decimal point is driven directly. It sits between the CPU debug/status path (PC, register or bus value) and the segment decoder.

## Interface
- SCAN_DIV, 100000: clock cycles per digit slot (≥ 2).
- BLANK_CYC, 1000: cycles at the start of each slot during which all anodes are off (anti-ghosting); < SCAN_DIV.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_data  in  32  value to show; nibble k drives digit k (digit 0 = rightmost).
- i_dp  in  8  per-digit decimal point request, active-high.
- i_load  in  1  single-cycle strobe; captures i_data and i_dp.
- i_lzs  in  1  leading-zero suppression enable (level, sampled live).
- o_nibble  out  4  nibble for the active digit, to the segment decoder.
- o_an  out  8  anode enables, active-low, one-hot-low or all-high.
- o_dp  out  1  decimal point, active-low.

## Operation
- Registers: cnt [$clog2(SCAN_DIV)-1:0], idx [2:0], pend_data[31:0]/pend_dp[7:0], pend flag, shadow_data/shadow_dp.
- cnt counts 0..SCAN_DIV-1 and wraps to 0. At wrap, idx increments modulo 8 (7→0).
- Frame boundary = cycle with idx==7 and cnt==SCAN_DIV-1.
- i_load=1: pend_data<=i_data, pend_dp<=i_dp, pend<=1. A later load before commit overwrites the pending value.
- At the frame boundary with pend=1 and i_load=0: shadow<=pending, pend<=0.
- Load coinciding with the boundary: the previously pending value commits; the new value becomes pending (pend stays 1) and commits at the next boundary. The display never changes mid-frame.
- Suppression: digit k (1..7) is blank when i_lzs=1 and shadow nibbles k..7 are all zero. Digit 0 is never suppressed, so a value of 0 shows "0".
- A slot is dark when cnt < BLANK_CYC or the digit is suppressed. A dark slot gives o_an=8'hFF and o_dp=1.
- Otherwise o_an = ~(8'b1<<idx), o_nibble = shadow_data[4*idx+:4], o_dp = ~shadow_dp[idx].
- o_nibble always tracks idx, even when the slot is dark.

## Timing
- All outputs are registered functions of the current cnt/idx/shadow, so they lag cnt/idx by exactly 1 cycle.
- Reset values:
  - cnt=0, idx=0, pend=0, pending=0, shadow=0.
  - o_an=8'hFF, o_nibble=0, o_dp=1.
- Reset asserted mid-frame: all state clears immediately and asynchronously. Scanning restarts from digit 0, slot start, after deassertion.
- First anode assertion after reset is at cycle BLANK_CYC+1 after deassertion.
- Load-to-display latency is at most 8·SCAN_DIV+1 cycles; it is exactly 1 cycle after the next boundary.
- Frame period = 8·SCAN_DIV cycles. Each digit is lit SCAN_DIV−BLANK_CYC cycles per frame.

## Structure
- Package seg7_pkg:
  - constants DIGITS=8, AN_OFF=8'hFF, DP_OFF=1'b1;
  - function lzs_mask(data) returning the 8-bit suppression mask.
- Sub-module seg7_tick (is natural): the SCAN_DIV prescaler. It outputs cnt and a one-cycle slot-wrap pulse; seg7_scan keeps idx, the shadow and the output logic.
- The segment decoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios use SCAN_DIV=4 and BLANK_CYC=1.
- Reset, then load 32'h1234_ABCD, dp=8'h01 → after the first boundary, digit 0 shows o_nibble=D, o_an=8'hFE, o_dp=0; digit 7 shows o_nibble=1, o_an=8'h7F, o_dp=1. Each digit is lit 3 of 4 cycles, with o_an=8'hFF in the first cycle of each slot.
- Load 32'h0000_0042, i_lzs=1 → only digits 0 and 1 light (2, 4); o_an=8'hFF in slots 2..7. With i_lzs=0, all 8 light with zeros.
- Load 32'h0 with i_lzs=1 → digit 0 shows 0; digits 1..7 stay dark.
- Load A mid-frame, then B on the boundary cycle → A displays for one full frame and B from the following frame. No frame mixes nibbles of A and B.
- Assert rst_n low during digit 5 → o_an=8'hFF asynchronously and the shadow clears to 0. After release, scanning starts at digit 0 and displays 0 until a load.
- Wrap check over 3 frames → idx sequence 0..7,0..7,0..7 with no skipped or doubled slot; the slot period is exactly 4 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the eight-digit seven-segment scan driver.
package seg7_pkg;

    localparam int unsigned DIGITS = 8;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DATA_W = DIGITS * NIB_W;
    localparam int unsigned IDX_W  = $clog2(DIGITS);

    localparam logic [DIGITS-1:0] AN_OFF = 8'hFF;
    localparam logic              DP_OFF = 1'b1;

    // Bit k set when nibbles k..7 are all zero; digit 0 is never suppressed.
    function automatic logic [DIGITS-1:0] lzs_mask(input logic [DATA_W-1:0] data);
        logic [DIGITS-1:0] mask;
        logic              zero_above;
        mask       = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (data[NIB_W*k +: NIB_W] == '0);
            mask[k]    = zero_above;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Load/display bundle between the status path, the scan driver and the segment decoder.
interface seg7_scan_if;
    import seg7_pkg::*;

    logic [DATA_W-1:0] i_data;
    logic [DIGITS-1:0] i_dp;
    logic              i_load;
    logic              i_lzs;
    logic [NIB_W-1:0]  o_nibble;
    logic [DIGITS-1:0] o_an;
    logic              o_dp;

    modport master (
        output i_data, i_dp, i_load, i_lzs,
        input  o_nibble, o_an, o_dp
    );

    modport slave (
        input  i_data, i_dp, i_load, i_lzs,
        output o_nibble, o_an, o_dp
    );

endinterface

// File: rtl/seg7_tick.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and flags the last cycle of each slot.
module seg7_tick #(
    parameter  int unsigned SCAN_DIV = 100000,
    localparam int unsigned CNT_W    = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    assign wrap_c = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (wrap_c) cnt <= '0;
        else             cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 8-digit common-anode scan driver with frame-synchronous value update
// and optional leading-zero suppression.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);

    localparam int unsigned        CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]   BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  cnt;
    logic              wrap_c;
    logic [IDX_W-1:0]  idx;
    logic              pend;
    logic [DATA_W-1:0] pend_data;
    logic [DIGITS-1:0] pend_dp;
    logic [DATA_W-1:0] shadow_data;
    logic [DIGITS-1:0] shadow_dp;

    logic              boundary_c;
    logic [DIGITS-1:0] mask_c;
    logic              dark_c;
    logic [DIGITS-1:0] an_c;
    logic [NIB_W-1:0]  nibble_c;
    logic              dp_c;

    seg7_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt    (cnt),
        .wrap_c (wrap_c)
    );

    assign boundary_c = wrap_c && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      idx <= '0;
        else if (wrap_c) idx <= idx + IDX_W'(1);
    end

    // A load on the boundary cycle still lets the older pending value commit first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= 1'b0;
            pend_data   <= '0;
            pend_dp     <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else begin
            if (boundary_c && pend) begin
                shadow_data <= pend_data;
                shadow_dp   <= pend_dp;
                pend        <= 1'b0;
            end
            if (bus.i_load) begin
                pend_data <= bus.i_data;
                pend_dp   <= bus.i_dp;
                pend      <= 1'b1;
            end
        end
    end

    always_comb begin
        mask_c   = lzs_mask(shadow_data);
        dark_c   = (cnt < BLANK_END) || (bus.i_lzs && mask_c[idx]);
        nibble_c = shadow_data[NIB_W*idx +: NIB_W];
        an_c     = AN_OFF;
        dp_c     = DP_OFF;
        if (!dark_c) begin
            an_c = ~(DIGITS'(1) << idx);
            dp_c = ~shadow_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_an     <= AN_OFF;
            bus.o_nibble <= '0;
            bus.o_dp     <= DP_OFF;
        end else begin
            bus.o_an     <= an_c;
            bus.o_nibble <= nibble_c;
            bus.o_dp     <= dp_c;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan with SCAN_DIV=4, BLANK_CYC=1: expected display
// samples are queued by edge number and checked by an independent monitor.
module tb_seg7_scan;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLANK_CYC = 1;

    typedef struct {
        int         at;
        logic [7:0] an;
        logic [3:0] nib;
        logic       dp;
        string      name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edge_n;
    int   checks;
    int   errors;
    exp_t q[$];

    seg7_scan_if sif ();

    seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release; outputs after edge n reflect time step n-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic cmp(input string name, input logic [7:0] an, input logic [3:0] nib, input logic dp);
        checks++;
        if (sif.o_an !== an || sif.o_nibble !== nib || sif.o_dp !== dp) begin
            errors++;
            $display("FAIL %s: got an=%h nib=%h dp=%b, want an=%h nib=%h dp=%b",
                     name, sif.o_an, sif.o_nibble, sif.o_dp, an, nib, dp);
        end
    endtask

    // Monitor: pops every entry due at the current edge count.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= edge_n) begin
            exp_t e;
            e = q.pop_front();
            if (e.at == edge_n) cmp(e.name, e.an, e.nib, e.dp);
            else begin
                checks++;
                errors++;
                $display("FAIL %s: sample slot missed (edge %0d), want edge %0d", e.name, edge_n, e.at);
            end
        end
    end

    task automatic push_vec(input int at, input logic [7:0] an, input logic [3:0] nib,
                            input logic dp, input string name);
        exp_t e;
        e.at = at; e.an = an; e.nib = nib; e.dp = dp; e.name = name;
        q.push_back(e);
    endtask

    // Expected display at time step t for a given shown value.
    task automatic push_range(input logic [31:0] d, input logic [7:0] p, input logic lz,
                              input int t_lo, input int t_hi);
        for (int t = t_lo; t <= t_hi; t++) begin
            int s, ph, h;
            logic [7:0] an;
            logic       dp;
            s = (t / 4) % 8;
            ph = t % 4;
            h = 0;
            for (int k = 0; k < 8; k++) if (d[4*k +: 4] != 4'h0) h = k;
            if (ph == 0 || (lz && s > h)) begin
                an = 8'hFF;
                dp = 1'b1;
            end else begin
                an = ~(8'h01 << s);
                dp = ~p[s];
            end
            push_vec(t + 1, an, d[4*s +: 4], dp, $sformatf("t%0d_dig%0d", t, s));
        end
    endtask

    task automatic goto_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic load_at(input int n, input logic [31:0] d, input logic [7:0] p);
        goto_edge(n - 1);
        sif.i_data = d;
        sif.i_dp   = p;
        sif.i_load = 1'b1;
        @(negedge clk);
        sif.i_load = 1'b0;
        sif.i_data = 32'h0;
        sif.i_dp   = 8'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at edge %0d, want finish", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        sif.i_data = 32'h0;
        sif.i_dp   = 8'h0;
        sif.i_load = 1'b0;
        sif.i_lzs  = 1'b0;
        rst_n      = 1'b0;
        push_vec(0, 8'hFF, 4'h0, 1'b1, "reset_values");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Frame 0: empty shadow, all digits show 0 lit from edge 2.
        push_range(32'h0, 8'h00, 1'b0, 0, 31);
        // Frame 1: 1234ABCD dp=01, with hand-computed first/last slots.
        push_vec(33, 8'hFF, 4'hD, 1'b1, "dig0_blank");
        push_vec(34, 8'hFE, 4'hD, 1'b0, "dig0_lit_a");
        push_vec(35, 8'hFE, 4'hD, 1'b0, "dig0_lit_b");
        push_vec(36, 8'hFE, 4'hD, 1'b0, "dig0_lit_c");
        push_range(32'h1234_ABCD, 8'h01, 1'b0, 36, 59);
        push_vec(61, 8'hFF, 4'h1, 1'b1, "dig7_blank");
        push_vec(62, 8'h7F, 4'h1, 1'b1, "dig7_lit_a");
        push_vec(63, 8'h7F, 4'h1, 1'b1, "dig7_lit_b");
        push_vec(64, 8'h7F, 4'h1, 1'b1, "dig7_lit_c");
        push_range(32'h0000_0042, 8'h02, 1'b1, 64, 95);   // frame 2: suppressed
        push_range(32'h0000_0042, 8'h02, 1'b0, 96, 127);  // frame 3: no suppression
        push_range(32'h0000_0000, 8'h00, 1'b1, 128, 159); // frame 4: zero, suppressed
        push_range(32'hCAFE_F00D, 8'hF0, 1'b1, 160, 191); // frame 5: A
        push_range(32'h8765_4321, 8'h0F, 1'b1, 192, 223); // frame 6: B
        push_range(32'h8765_4321, 8'h0F, 1'b1, 224, 246); // frame 7 up to digit 5

        load_at(5, 32'h1234_ABCD, 8'h01);
        load_at(45, 32'h0000_0042, 8'h02);
        goto_edge(64);  sif.i_lzs = 1'b1;
        goto_edge(96);  sif.i_lzs = 1'b0;
        load_at(100, 32'hDEAD_BEEF, 8'hAA);
        load_at(110, 32'h0000_0000, 8'h00);
        goto_edge(128); sif.i_lzs = 1'b1;
        load_at(140, 32'hCAFE_F00D, 8'hF0);
        load_at(160, 32'h8765_4321, 8'h0F);

        // Asynchronous reset in the middle of digit 5.
        goto_edge(247);
        #2 rst_n = 1'b0;
        #1 cmp("async_reset", 8'hFF, 4'h0, 1'b1);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pre_reset_queue: %0d entries left, want 0", q.size());
            q.delete();
        end
        push_vec(0, 8'hFF, 4'h0, 1'b1, "reset_hold");
        push_range(32'h0, 8'h00, 1'b1, 0, 63);
        @(negedge clk);
        #2 rst_n = 1'b1;

        goto_edge(66);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d entries left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
